alu_gen2: RTL and testbench
===========================

ALU_GEN2 -- requirements
Module: alu_gen2

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data-path width in bits (min 4).
REQ-002 SHALL provide parameter PC_W, default 12, program-counter width in bits.
REQ-003 SHALL provide parameter MUL_EN, default 1; 1 includes the iterative multiplier, 0 treats MUL as an illegal opcode.
REQ-004 pixel_clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  start request; sampled only in IDLE.
REQ-007 operation  in  8  opcode.
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 pc  in  PC_W  current program counter.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  one-cycle pulse when results are valid.
REQ-012 illegal  out  1  one-cycle pulse with done for an undefined opcode.
REQ-013 a_out, b_out  out  WIDTH each  result registers.
REQ-014 pcnew  out  PC_W  next program counter.
REQ-015 status  out  6  flags: [5] Z, [4] C, [3] U underflow, [2] V overflow, [1] I interrupt enable, [0] N.
REQ-016 ion  out  1  interrupt enable; always equals status[1].

Function
REQ-017 FSM SHALL have states IDLE, EXEC, MUL and DONE.
REQ-018 IDLE with run=1: latch operation, a, b and pc, then go to MUL if opcode is MUL and MUL_EN=1, else go to EXEC.
REQ-019 EXEC: compute the result and go to DONE.
REQ-020 DONE: drive done=1 for one cycle, then return to IDLE.
REQ-021 busy=1 in EXEC, MUL and DONE; run SHALL be ignored whenever busy=1.
REQ-022 Latency: run sampled at edge k; results, pcnew and status update at edge k+1; done is high between edges k+1 and k+2.
REQ-023 MUL latency: results at edge k+WIDTH+1.
REQ-024 Opcodes: 0x71 ADD a_out=a+b; 0x72 AND a_out=a&b; 0x73 CLA a_out=0; 0x74 CLB b_out=0; 0x75 CMB b_out=~b; 0x76 INCB b_out=b+1; 0x77 DECB b_out=b-1; 0x7E SUB a_out=a-b.
REQ-025 Opcodes: 0x78 CLC clears C; 0x79 CLZ clears Z; 0x7A ION sets I; 0x7B IOF clears I; 0x7C SC; 0x7D SZ; 0x7F MUL; 0x80 SHL a_out=a<<1; 0x81 SHR a_out=a>>1 (logical).
REQ-026 MUL: unsigned shift-add, one partial product per cycle for WIDTH cycles; {b_out,a_out} = full 2*WIDTH-bit product.
REQ-027 Arithmetic opcodes SHALL recompute Z, N, C, U and V (set or clear) from the WIDTH-bit result; flags are not sticky.
REQ-028 Z=(result==0); N=result msb.
REQ-029 C: carry-out for ADD and INCB; borrow for SUB and DECB; shifted-out bit for SHL and SHR; upper half nonzero for MUL; 0 for AND and CMB.
REQ-030 V: signed overflow for ADD, SUB, INCB and DECB; 0 otherwise.
REQ-031 U: 1 only when DECB wraps from 0; 0 otherwise.
REQ-032 CLA and CLB SHALL set Z=1 and leave the other flags unchanged.
REQ-033 Result registers not written by an opcode SHALL hold their values.
REQ-034 SC/SZ: pcnew=pc+1 modulo 2^PC_W if C (for SC) or Z (for SZ) is 1, else pcnew=pc; all other opcodes give pcnew=pc.
REQ-035 Undefined opcode: no result or flag change, pcnew=pc, illegal pulses together with done.
REQ-036 Flag ops (CLC, CLZ, ION, IOF) and SC/SZ take EXEC latency.

Reset
REQ-037 reset_n=0 SHALL immediately force: state IDLE, busy=0, done=0, illegal=0, a_out=0, b_out=0, pcnew=0, status=0, ion=0.
REQ-038 Reset mid-operation SHALL abort the operation with no done pulse; the first run after reset_n rises starts a fresh operation.

Verification
REQ-039 ADD, a=0xFFFF, b=0x0001, WIDTH=16 -> a_out=0x0000, Z=1, C=1, N=0, V=0; done exactly 2 edges after run.
REQ-040 MUL, a=0x00FF, b=0x0101 -> a_out=0xFFFF, b_out=0x0000, C=0; done after 17 edges; a second run pulse mid-multiply is ignored.
REQ-041 DECB, b=0x0000 -> b_out=0xFFFF, U=1, C=1, N=1, Z=0; a following INCB, b=0x0001 -> U=0, C=0.
REQ-042 SZ with Z=1, pc=0xFFF -> pcnew=0x000; SC with C=0, pc=0x123 -> pcnew=0x123.
REQ-043 reset_n low during MUL cycle 5 -> all outputs 0 immediately, no done pulse; ION after release -> status=0x02, ion=1.
REQ-044 opcode 0x00 -> illegal and done pulse together, status and results unchanged, pcnew=pc.

Source files
------------

// File: rtl/alu_gen2_if.sv
// Request/response bundle for alu_gen2: operands and opcode in, results, flags and handshake out.
interface alu_gen2_if #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 12
);
    logic             run;
    logic [7:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [PC_W-1:0]  pcnew;
    logic [5:0]       status;
    logic             ion;

    modport master (
        output run, operation, a, b, pc,
        input  busy, done, illegal, a_out, b_out, pcnew, status, ion
    );

    modport slave (
        input  run, operation, a, b, pc,
        output busy, done, illegal, a_out, b_out, pcnew, status, ion
    );
endinterface

// File: rtl/alu_gen2.sv
// Small sequential ALU: single-cycle ops via EXEC, optional WIDTH-cycle shift-add multiplier,
// skip-style pc update and a 6-bit Z/C/U/V/I/N status register.
module alu_gen2 #(
    parameter int WIDTH  = 16,
    parameter int PC_W   = 12,
    parameter int MUL_EN = 1
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    alu_gen2_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [7:0] OP_ADD  = 8'h71, OP_AND  = 8'h72, OP_CLA = 8'h73, OP_CLB = 8'h74;
    localparam logic [7:0] OP_CMB  = 8'h75, OP_INCB = 8'h76, OP_DECB = 8'h77, OP_CLC = 8'h78;
    localparam logic [7:0] OP_CLZ  = 8'h79, OP_ION  = 8'h7A, OP_IOF = 8'h7B, OP_SC  = 8'h7C;
    localparam logic [7:0] OP_SZ   = 8'h7D, OP_SUB  = 8'h7E, OP_MUL = 8'h7F, OP_SHL = 8'h80;
    localparam logic [7:0] OP_SHR  = 8'h81;
    localparam logic [WIDTH:0] ONE_X = 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             state;
    logic [7:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [PC_W-1:0]    pc_r;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;

    logic               busy_q, done_q, ill_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [PC_W-1:0]    pc_q;
    logic [5:0]         st_q;

    logic [WIDTH-1:0]   ex_a, ex_b;
    logic [PC_W-1:0]    ex_pc;
    logic [5:0]         ex_st;
    logic               ex_ill;

    logic [WIDTH:0]     sum, dif, inc, dec;
    logic               v_add, v_sub, v_inc, v_dec;

    // Flag layout: {Z, C, U, V, I, N}; I is carried through untouched.
    function automatic logic [5:0] arith(input logic [5:0] st, input logic [WIDTH-1:0] r,
                                         input logic c, input logic u, input logic v);
        return {r == '0, c, u, v, st[1], r[WIDTH-1]};
    endfunction

    assign sum   = {1'b0, a_r} + {1'b0, b_r};
    assign dif   = {1'b0, a_r} - {1'b0, b_r};
    assign inc   = {1'b0, b_r} + ONE_X;
    assign dec   = {1'b0, b_r} - ONE_X;
    assign v_add = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
    assign v_sub = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (dif[WIDTH-1] != a_r[WIDTH-1]);
    assign v_inc = !b_r[WIDTH-1] && inc[WIDTH-1];
    assign v_dec = b_r[WIDTH-1] && !dec[WIDTH-1];

    always_comb begin
        ex_a   = a_q;
        ex_b   = b_q;
        ex_st  = st_q;
        ex_pc  = pc_r;
        ex_ill = 1'b0;
        case (op_r)
            OP_ADD:  begin ex_a = sum[WIDTH-1:0]; ex_st = arith(st_q, sum[WIDTH-1:0], sum[WIDTH], 1'b0, v_add); end
            OP_SUB:  begin ex_a = dif[WIDTH-1:0]; ex_st = arith(st_q, dif[WIDTH-1:0], dif[WIDTH], 1'b0, v_sub); end
            OP_AND:  begin ex_a = a_r & b_r; ex_st = arith(st_q, a_r & b_r, 1'b0, 1'b0, 1'b0); end
            OP_CLA:  begin ex_a = '0; ex_st[5] = 1'b1; end
            OP_CLB:  begin ex_b = '0; ex_st[5] = 1'b1; end
            OP_CMB:  begin ex_b = ~b_r; ex_st = arith(st_q, ~b_r, 1'b0, 1'b0, 1'b0); end
            OP_INCB: begin ex_b = inc[WIDTH-1:0]; ex_st = arith(st_q, inc[WIDTH-1:0], inc[WIDTH], 1'b0, v_inc); end
            OP_DECB: begin ex_b = dec[WIDTH-1:0]; ex_st = arith(st_q, dec[WIDTH-1:0], dec[WIDTH], b_r == '0, v_dec); end
            OP_SHL:  begin
                ex_a  = {a_r[WIDTH-2:0], 1'b0};
                ex_st = arith(st_q, {a_r[WIDTH-2:0], 1'b0}, a_r[WIDTH-1], 1'b0, 1'b0);
            end
            OP_SHR:  begin
                ex_a  = {1'b0, a_r[WIDTH-1:1]};
                ex_st = arith(st_q, {1'b0, a_r[WIDTH-1:1]}, a_r[0], 1'b0, 1'b0);
            end
            OP_CLC:  ex_st[4] = 1'b0;
            OP_CLZ:  ex_st[5] = 1'b0;
            OP_ION:  ex_st[1] = 1'b1;
            OP_IOF:  ex_st[1] = 1'b0;
            OP_SC:   if (st_q[4]) ex_pc = pc_r + PC_W'(1);
            OP_SZ:   if (st_q[5]) ex_pc = pc_r + PC_W'(1);
            default: ex_ill = 1'b1;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            pc_r   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            pc_q   <= '0;
            st_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    ill_q  <= 1'b0;
                    if (bus.run) begin
                        op_r   <= bus.operation;
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        pc_r   <= bus.pc;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                        busy_q <= 1'b1;
                        state  <= (MUL_EN != 0 && bus.operation == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    a_q    <= ex_a;
                    b_q    <= ex_b;
                    st_q   <= ex_st;
                    pc_q   <= ex_pc;
                    ill_q  <= ex_ill;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                MUL: begin
                    // WIDTH accumulate cycles, then one cycle to publish the product.
                    if (cnt == CNT_W'(WIDTH)) begin
                        a_q    <= acc[WIDTH-1:0];
                        b_q    <= acc[2*WIDTH-1:WIDTH];
                        st_q   <= arith(st_q, acc[WIDTH-1:0], |acc[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
                        pc_q   <= pc_r;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    ill_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = ill_q;
    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.pcnew   = pc_q;
    assign bus.status  = st_q;
    assign bus.ion     = st_q[1];
endmodule

// File: tb/tb_alu_gen2.sv
// Table-driven bench for alu_gen2 with a done-time scoreboard, plus multiply, reset-abort sequences.
module tb_alu_gen2;
    localparam int WIDTH = 16;
    localparam int PC_W  = 12;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a, b;
        logic [11:0] pc;
        logic [15:0] ea, eb;
        logic [11:0] epc;
        logic [5:0]  est, smask;
        logic        ill;
        int          lat;
        int          due;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t vecs[$];

    alu_gen2_if #(.WIDTH(WIDTH), .PC_W(PC_W)) bus();
    alu_gen2 #(.WIDTH(WIDTH), .PC_W(PC_W), .MUL_EN(1)) dut (
        .pixel_clock(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [11:0] pc, input logic [15:0] ea, input logic [15:0] eb,
                                input logic [11:0] epc, input logic [5:0] est, input logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pc = pc;
        v.ea = ea; v.eb = eb; v.epc = epc; v.est = est; v.smask = 6'h3F;
        v.ill = ill; v.lat = (op == 8'h7F) ? WIDTH + 1 : 1; v.due = 0;
        return v;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("a_out", bus.a_out, e.ea);
                chk("b_out", bus.b_out, e.eb);
                chk("pcnew", bus.pcnew, e.epc);
                chk("status", bus.status & e.smask, e.est & e.smask);
                chk("ion", bus.ion, e.est[1]);
                chk("illegal", bus.illegal, e.ill);
                chk("busy_at_done", bus.busy, 1'b1);
            end
        end else if (bus.illegal) begin
            chk("illegal_without_done", bus.illegal, 1'b0);
        end
    end

    task automatic do_op(input vec_t v, input bit glitch);
        vec_t e;
        int i;
        @(negedge clk);
        bus.run = 1'b1; bus.operation = v.op; bus.a = v.a; bus.b = v.b; bus.pc = v.pc;
        e = v;
        e.due = cyc + 1 + v.lat;
        sb.push_back(e);
        @(negedge clk);
        bus.run = 1'b0;
        if (glitch) begin
            repeat (4) @(negedge clk);
            bus.run = 1'b1; bus.operation = 8'h71; bus.a = 16'h0001; bus.b = 16'h0001;
            @(negedge clk);
            bus.run = 1'b0;
        end
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(negedge clk); #1;
            i++;
        end
        chk("done_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk); #1;
        chk("idle_busy", bus.busy, 1'b0);
        if (glitch) repeat (6) @(negedge clk);
    endtask

    initial begin
        vec_t mv;
        bus.run = 1'b0; bus.operation = '0; bus.a = '0; bus.b = '0; bus.pc = '0;

        vecs.push_back(mk(8'h71, 16'hFFFF, 16'h0001, 12'h010, 16'h0000, 16'h0000, 12'h010, 6'h30, 1'b0));
        vecs.push_back(mk(8'h7D, 16'h0000, 16'h0000, 12'hFFF, 16'h0000, 16'h0000, 12'h000, 6'h30, 1'b0));
        vecs.push_back(mk(8'h78, 16'h0000, 16'h0000, 12'h050, 16'h0000, 16'h0000, 12'h050, 6'h20, 1'b0));
        vecs.push_back(mk(8'h7C, 16'h0000, 16'h0000, 12'h123, 16'h0000, 16'h0000, 12'h123, 6'h20, 1'b0));
        vecs.push_back(mk(8'h7E, 16'h0003, 16'h0005, 12'h001, 16'hFFFE, 16'h0000, 12'h001, 6'h11, 1'b0));
        vecs.push_back(mk(8'h7C, 16'h0000, 16'h0000, 12'h200, 16'hFFFE, 16'h0000, 12'h201, 6'h11, 1'b0));
        vecs.push_back(mk(8'h77, 16'h0000, 16'h0000, 12'h002, 16'hFFFE, 16'hFFFF, 12'h002, 6'h19, 1'b0));
        vecs.push_back(mk(8'h76, 16'h0000, 16'h0001, 12'h003, 16'hFFFE, 16'h0002, 12'h003, 6'h00, 1'b0));
        vecs.push_back(mk(8'h71, 16'h7FFF, 16'h0001, 12'h004, 16'h8000, 16'h0002, 12'h004, 6'h05, 1'b0));
        vecs.push_back(mk(8'h7A, 16'h0000, 16'h0000, 12'h001, 16'h8000, 16'h0002, 12'h001, 6'h07, 1'b0));
        vecs.push_back(mk(8'h72, 16'hF0F0, 16'h0FF0, 12'h005, 16'h00F0, 16'h0002, 12'h005, 6'h02, 1'b0));
        vecs.push_back(mk(8'h75, 16'h0000, 16'h00FF, 12'h006, 16'h00F0, 16'hFF00, 12'h006, 6'h03, 1'b0));
        vecs.push_back(mk(8'h80, 16'h8001, 16'h0000, 12'h007, 16'h0002, 16'hFF00, 12'h007, 6'h12, 1'b0));
        vecs.push_back(mk(8'h73, 16'h0000, 16'h0000, 12'h008, 16'h0000, 16'hFF00, 12'h008, 6'h32, 1'b0));
        vecs.push_back(mk(8'h79, 16'h0000, 16'h0000, 12'h009, 16'h0000, 16'hFF00, 12'h009, 6'h12, 1'b0));
        vecs.push_back(mk(8'h81, 16'h0003, 16'h0000, 12'h00A, 16'h0001, 16'hFF00, 12'h00A, 6'h12, 1'b0));
        vecs.push_back(mk(8'h74, 16'h0000, 16'h0000, 12'h00B, 16'h0001, 16'h0000, 12'h00B, 6'h32, 1'b0));
        vecs.push_back(mk(8'h7B, 16'h0000, 16'h0000, 12'h00C, 16'h0001, 16'h0000, 12'h00C, 6'h30, 1'b0));
        vecs.push_back(mk(8'h76, 16'h0000, 16'h7FFF, 12'h00D, 16'h0001, 16'h8000, 12'h00D, 6'h05, 1'b0));
        vecs.push_back(mk(8'h77, 16'h0000, 16'h8000, 12'h00E, 16'h0001, 16'h7FFF, 12'h00E, 6'h04, 1'b0));
        vecs.push_back(mk(8'h00, 16'h1234, 16'h5678, 12'h0AB, 16'h0001, 16'h7FFF, 12'h0AB, 6'h04, 1'b1));
        mv = mk(8'h7F, 16'hFFFF, 16'hFFFF, 12'h0C0, 16'h0001, 16'hFFFE, 12'h0C0, 6'h10, 1'b0);
        mv.smask = 6'h3E;
        vecs.push_back(mv);

        repeat (3) @(negedge clk);
        chk("rst_a_out", bus.a_out, 16'h0);
        chk("rst_b_out", bus.b_out, 16'h0);
        chk("rst_pcnew", bus.pcnew, 12'h0);
        chk("rst_status", bus.status, 6'h0);
        chk("rst_ion", bus.ion, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i], 1'b0);

        // Multiply with a stray run pulse while busy: exactly one done, product unaffected.
        mv = mk(8'h7F, 16'h00FF, 16'h0101, 12'h0D0, 16'hFFFF, 16'h0000, 12'h0D0, 6'h00, 1'b0);
        mv.smask = 6'h3E;
        do_op(mv, 1'b1);

        // Abort a multiply partway through with reset.
        @(negedge clk);
        bus.run = 1'b1; bus.operation = 8'h7F; bus.a = 16'h1234; bus.b = 16'h00FF; bus.pc = 12'h0E0;
        @(posedge clk);
        #1 bus.run = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_a_out", bus.a_out, 16'h0);
        chk("abort_b_out", bus.b_out, 16'h0);
        chk("abort_pcnew", bus.pcnew, 12'h0);
        chk("abort_status", bus.status, 6'h0);
        chk("abort_ion", bus.ion, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_illegal", bus.illegal, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_abort_busy", bus.busy, 1'b0);

        do_op(mk(8'h7A, 16'h0000, 16'h0000, 12'h045, 16'h0000, 16'h0000, 12'h045, 6'h02, 1'b0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
